// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO and its RAM.
// Also holds the packed record of safety-monitor invariant checks.
package fifo_pkg;

   localparam int unsigned FIFO_DEPTH_DFLT = 16;
   localparam int unsigned DATA_WIDTH_DFLT = 32;

   // One bit per invariant watched by the safety monitor.
   typedef struct packed {
      logic cnt_mismatch;
      logic cnt_overrange;
      logic empty_and_full;
      logic full_not_half;
   } mon_flags_t;

   function automatic int unsigned addr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge returns the old word.
module fifo_sdpram #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_array [DEPTH];

   // Non-blocking update of both ports gives read-before-write on collision.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_array[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem_array[raddr];
      end
   end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO with active-low status flags, sticky error flag and a
// sticky safety monitor over the pointer/count invariants.
module fifo
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DFLT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT
) (
   input  logic                  Clock,
   input  logic                  Reset_,
   input  logic                  WriteEn,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic                  ReadEn,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  Empty_,
   output logic                  HalfFull_,
   output logic                  Full_,
   output logic                  Error_,
   output logic                  detected_error
);

   localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH);
   localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(FIFO_DEPTH / 2);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0]  r_wr_ptr;
   logic [CNT_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_out_valid;
   logic                  r_error_n;
   logic                  r_detected_error;

   logic [CNT_WIDTH-1:0]  w_wr_ptr;
   logic [CNT_WIDTH-1:0]  w_rd_ptr;
   logic [CNT_WIDTH-1:0]  w_count;
   logic                  w_out_valid;
   logic                  w_error_n;
   logic                  w_detected_error;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_half;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_overflow;
   logic                  w_underflow;
   logic [DATA_WIDTH-1:0] w_rdata;
   mon_flags_t            w_mon;

   // Flags decode the registered count only.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);
   assign w_half  = (r_count >= CNT_HALF);

   assign w_rd_acc    = ReadEn & ~w_empty;
   assign w_wr_acc    = WriteEn & (~w_full | w_rd_acc);
   assign w_overflow  = WriteEn & ~w_wr_acc;
   assign w_underflow = ReadEn & w_empty;

   always_comb begin
      w_wr_ptr    = r_wr_ptr;
      w_rd_ptr    = r_rd_ptr;
      w_count     = r_count;
      w_out_valid = r_out_valid;
      w_error_n   = r_error_n;

      if (w_wr_acc) begin
         w_wr_ptr = r_wr_ptr + CNT_ONE;
      end
      if (w_rd_acc) begin
         w_rd_ptr    = r_rd_ptr + CNT_ONE;
         w_out_valid = 1'b1;
      end

      unique case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count = r_count + CNT_ONE;
         2'b01:   w_count = r_count - CNT_ONE;
         default: w_count = r_count;
      endcase

      if (w_overflow || w_underflow) begin
         w_error_n = 1'b0;
      end
   end

   always_comb begin
      w_mon.cnt_mismatch   = (r_count != (r_wr_ptr - r_rd_ptr));
      w_mon.cnt_overrange  = (r_count > CNT_FULL);
      w_mon.empty_and_full = w_empty & w_full;
      w_mon.full_not_half  = w_full & ~w_half;
      w_detected_error     = r_detected_error | (|w_mon);
   end

   always_ff @(posedge Clock or posedge Reset_) begin
      if (Reset_) begin
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         r_out_valid      <= 1'b0;
         r_error_n        <= 1'b1;
         r_detected_error <= 1'b0;
      end else begin
         r_wr_ptr         <= w_wr_ptr;
         r_rd_ptr         <= w_rd_ptr;
         r_count          <= w_count;
         r_out_valid      <= w_out_valid;
         r_error_n        <= w_error_n;
         r_detected_error <= w_detected_error;
      end
   end

   fifo_sdpram #(
      .DEPTH      (FIFO_DEPTH),
      .WIDTH      (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (Clock),
      .we    (w_wr_acc),
      .waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (DataIn),
      .re    (w_rd_acc),
      .raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (w_rdata)
   );

   // The RAM read register is not reset; mask it until the first accepted read.
   assign DataOut        = r_out_valid ? w_rdata : '0;
   assign Empty_         = ~w_empty;
   assign HalfFull_      = ~w_half;
   assign Full_          = ~w_full;
   assign Error_         = r_error_n;
   assign detected_error = r_detected_error;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 32;

   logic          Clock = 1'b0;
   logic          Reset_;
   logic          WriteEn;
   logic          ReadEn;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] DataOut;
   logic          Empty_;
   logic          HalfFull_;
   logic          Full_;
   logic          Error_;
   logic          detected_error;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   logic          m_err;

   always #5 Clock = ~Clock;

   fifo #(
      .FIFO_DEPTH (DEPTH),
      .DATA_WIDTH (DW)
   ) dut (
      .Clock          (Clock),
      .Reset_         (Reset_),
      .WriteEn        (WriteEn),
      .DataIn         (DataIn),
      .ReadEn         (ReadEn),
      .DataOut        (DataOut),
      .Empty_         (Empty_),
      .HalfFull_      (HalfFull_),
      .Full_          (Full_),
      .Error_         (Error_),
      .detected_error (detected_error)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ":DataOut"},   DataOut,                m_dout);
      check({tag, ":Empty_"},    DW'(Empty_),            DW'(n != 0));
      check({tag, ":HalfFull_"}, DW'(HalfFull_),         DW'(n < DEPTH / 2));
      check({tag, ":Full_"},     DW'(Full_),             DW'(n != DEPTH));
      check({tag, ":Error_"},    DW'(Error_),            DW'(!m_err));
      check({tag, ":detected"},  DW'(detected_error),    '0);
   endtask

   // One clock of traffic; the model applies the FIFO rules to pre-edge occupancy.
   task automatic step(input logic we, input logic re, input logic [DW-1:0] din,
                       input string tag);
      bit rd_ok;
      bit wr_ok;
      WriteEn = we;
      ReadEn  = re;
      DataIn  = din;
      @(posedge Clock);
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      if ((we && !wr_ok) || (re && !rd_ok)) m_err = 1'b1;
      #1;
      check_all(tag);
   endtask

   // Called one time unit after an edge; asserts reset mid-cycle.
   task automatic do_reset(input string tag);
      #2;
      WriteEn = 1'b0;
      ReadEn  = 1'b0;
      Reset_  = 1'b1;
      q.delete();
      m_dout = '0;
      m_err  = 1'b0;
      #1;
      check_all({tag, ":in_reset"});
      @(posedge Clock);
      #1;
      Reset_ = 1'b0;
      check_all({tag, ":after_reset"});
   endtask

   initial begin
      Reset_  = 1'b0;
      WriteEn = 1'b0;
      ReadEn  = 1'b0;
      DataIn  = '0;
      m_dout  = '0;
      m_err   = 1'b0;
      #1;
      do_reset("por");

      // Fill then drain with 1..16.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
      for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, '0, "drain");

      // Overflow: the extra word is dropped.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), "ovf_fill");
      step(1'b1, 1'b0, 32'hDEAD, "ovf_write");
      for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, '0, "ovf_drain");

      // Mid-operation reset with data held in DataOut and words still stored.
      step(1'b1, 1'b0, 32'h1234, "pre_rst_w0");
      step(1'b1, 1'b0, 32'h5678, "pre_rst_w1");
      step(1'b0, 1'b1, '0, "pre_rst_r");
      do_reset("mid_op");

      // Underflow straight after reset.
      step(1'b0, 1'b1, '0, "underflow");
      step(1'b0, 1'b0, '0, "underflow_hold");
      do_reset("rst2");

      // Both enables while empty, then while full.
      step(1'b1, 1'b1, 32'hA5, "rw_empty");
      step(1'b0, 1'b1, '0, "rw_empty_rd");
      do_reset("rst3");
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(32'h100 + i), "rwf_fill");
      step(1'b1, 1'b1, 32'hBEEF, "rw_full");
      step(1'b1, 1'b1, 32'hCAFE, "rw_full2");
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "rwf_drain");
      do_reset("rst4");

      // Pointer wrap: 3 writes then 2 reads, repeated.
      for (int i = 0; i < 40; i++) begin
         if ((i % 5) < 3) step(1'b1, 1'b0, DW'(32'h200 + i), "wrap_w");
         else             step(1'b0, 1'b1, '0, "wrap_r");
      end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "wrap_drain");
      do_reset("rst5");

      // Random traffic: write-biased then read-biased phases.
      for (int i = 0; i < 600; i++) begin
         int wbias;
         wbias = ((i / 100) % 2 == 0) ? 70 : 30;
         if ($urandom_range(0, 249) == 0) begin
            do_reset("rnd_rst");
         end else begin
            step(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) < (100 - wbias)),
                 DW'($urandom), "rnd");
         end
      end
      do_reset("rst6");

      // Corrupt the count; the monitor must flag it on the next edge.
      step(1'b1, 1'b0, 32'h77, "pre_force");
      force dut.r_count = 5'd17;
      @(posedge Clock);
      #1;
      check("monitor_detect", DW'(detected_error), DW'(1));
      release dut.r_count;
      do_reset("post_force");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO of FIFO_DEPTH words × DATA_WIDTH bits, built on a simple-dual-port RAM.
- Provides active-low empty, half-full, full and error flags.
- Contains a built-in safety monitor that raises detected_error when internal pointer/count invariants break.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- FIFO_DEPTH, 16: number of words; power of two, ≥4.
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, $clog2(FIFO_DEPTH): derived localparam, not overridable.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_  in  1  asynchronous, active-high reset.
- WriteEn  in  1  write request.
- DataIn  in  DATA_WIDTH  write data.
- ReadEn  in  1  read request.
- DataOut  out  DATA_WIDTH  registered read data.
- Empty_  out  1  low when FIFO holds 0 words.
- HalfFull_  out  1  low when count ≥ FIFO_DEPTH/2.
- Full_  out  1  low when count == FIFO_DEPTH.
- Error_  out  1  low (sticky) after any overflow or underflow attempt.
- detected_error  out  1  high (sticky) when the safety monitor detects an invariant violation.

Behaviour:
- Reset (asynchronous, Reset_=1), reset values:
  - wr_ptr, rd_ptr, count = 0; DataOut = 0.
  - Empty_ = 0, HalfFull_ = 1, Full_ = 1, Error_ = 1, detected_error = 0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored words immediately.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit. The address is the low ADDR_WIDTH bits, so addresses wrap FIFO_DEPTH-1 → 0. count is ADDR_WIDTH+1 bits, range 0..FIFO_DEPTH.
- Write accept: WriteEn=1 and (Full_=1 or read accepted same cycle) → mem[wr_addr] ← DataIn, wr_ptr+1.
- Read accept: ReadEn=1 and Empty_=1 → DataOut ← mem[rd_addr], rd_ptr+1.
  - Latency: data appears on DataOut after the same rising edge (one-cycle registered read).
  - DataOut holds its value when no read is accepted.
- All accept decisions use pre-edge state.
- count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Flags are combinational decodes of the registered count.
- Simultaneous WriteEn and ReadEn:
  - Empty: write accepted, read rejected → underflow.
  - Full: both accepted. The read returns the old word (read-before-write on the shared address). count stays FIFO_DEPTH, Error_ unaffected.
  - Otherwise: both accepted.
- Overflow: WriteEn=1 while full with no accepted read → write dropped, Error_ ← 0.
- Underflow: ReadEn=1 while empty → DataOut unchanged, Error_ ← 0.
- Error_ stays 0 until reset.
- Safety monitor (registered, sticky until reset): sets detected_error=1 on the edge after any of:
  - count != (wr_ptr − rd_ptr) mod 2^(ADDR_WIDTH+1)
  - count > FIFO_DEPTH
  - Empty_=0 and Full_=0 simultaneously
  - Full_=0 while HalfFull_=1
  
  In fault-free operation detected_error never asserts.

Decomposition:
- Shared package fifo_pkg: default FIFO_DEPTH/DATA_WIDTH constants and a function for ADDR_WIDTH.
- One sub-module, fifo_sdpram: simple dual-port RAM.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata; registered read; read-before-write on address collision.
  - Storage array named mem_array, no reset.
- Pointer/count logic, flag decode and the safety monitor stay in fifo.

Test Plan:
- Reset: assert Reset_ asynchronously mid-cycle → within the same cycle Empty_=0, HalfFull_=1, Full_=1, Error_=1, detected_error=0, DataOut=0.
- Fill then drain: write 0x1..0x10 (16 words) → HalfFull_ falls after the 8th write, Full_ falls after the 16th. Then 16 reads → DataOut 0x1..0x10 in order, each one edge after its read; Empty_=0 after the last read. Error_=1 and detected_error=0 throughout.
- Overflow: fill 16 words, write 0xDEAD → Error_=0, count stays 16. Draining yields 0x1..0x10, never 0xDEAD.
- Underflow: after reset, assert ReadEn → Error_=0, DataOut stays 0, Empty_ stays 0.
- Simultaneous R/W:
  - Empty plus both enables with DataIn=0xA5 → one word stored, Error_=0.
  - Full plus both enables → oldest word is read out, new word is written, Full_ stays 0, Error_ unchanged.
- Wrap-around: repeat 40 cycles of 3 writes / 2 reads with incrementing data → in-order data across pointer wrap, detected_error stays 0. Forcing count to 17 via force → detected_error=1 on the next edge.
